// File: rtl/pipelined_addsub_if.sv
// Operand/result handshake bundle for pipelined_addsub.
// The master side drives operands and out_ready; the slave side is the adder.
interface pipelined_addsub_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output in_valid, a_in, b_in, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, overflow
  );

  modport slave (
    input  in_valid, a_in, b_in, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, overflow
  );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined ripple-carry adder/subtractor: WIDTH/CHUNK ripple stages with a
// registered carry between them, valid/ready handshake and carry/overflow flags.
module pipelined_addsub #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input logic               CLOCK_50,
  input logic               reset,
  pipelined_addsub_if.slave bus
);
  localparam int STAGES = WIDTH / CHUNK;

  // Returns {overflow, carry_out, sum} for one chunk of full adders.
  function automatic logic [CHUNK+1:0] ripple_chunk(input logic [CHUNK-1:0] a,
                                                    input logic [CHUNK-1:0] b,
                                                    input logic             c0);
    logic [CHUNK-1:0] s;
    logic             c;
    logic             c_top;
    s     = '0;
    c     = c0;
    c_top = c0;
    for (int i = 0; i < CHUNK; i++) begin
      if (i == CHUNK - 1) c_top = c;
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    return {c_top ^ c, c, s};
  endfunction

  logic             vld_p   [STAGES];
  logic             cy_p    [STAGES];
  logic             ov_p    [STAGES];
  logic [WIDTH-1:0] res_p   [STAGES];
  logic [WIDTH-1:0] a_p     [STAGES];
  logic [WIDTH-1:0] b_p     [STAGES];

  logic             nxt_vld [STAGES];
  logic             nxt_cy  [STAGES];
  logic             nxt_ov  [STAGES];
  logic [WIDTH-1:0] nxt_res [STAGES];
  logic [WIDTH-1:0] nxt_a   [STAGES];
  logic [WIDTH-1:0] nxt_b   [STAGES];

  logic advance;
  logic take;

  assign advance = !vld_p[STAGES-1] || bus.out_ready;
  assign take    = bus.in_valid && advance;

  always_comb begin
    logic [CHUNK+1:0] r;
    for (int k = 0; k < STAGES; k++) begin
      nxt_vld[k] = 1'b0;
      nxt_cy[k]  = 1'b0;
      nxt_ov[k]  = 1'b0;
      nxt_res[k] = '0;
      nxt_a[k]   = '0;
      nxt_b[k]   = '0;
    end

    // Stage 0: subtract folds into A + ~B + 1, so cin is replaced by sub.
    nxt_vld[0] = take;
    nxt_a[0]   = bus.a_in;
    nxt_b[0]   = bus.sub ? ~bus.b_in : bus.b_in;
    r = ripple_chunk(nxt_a[0][CHUNK-1:0], nxt_b[0][CHUNK-1:0], bus.sub | bus.cin);
    nxt_res[0][CHUNK-1:0] = r[CHUNK-1:0];
    nxt_cy[0]  = r[CHUNK];
    nxt_ov[0]  = r[CHUNK+1];

    // Stage k: sum chunk k from the carry registered by stage k-1.
    for (int k = 1; k < STAGES; k++) begin
      nxt_vld[k] = vld_p[k-1];
      nxt_a[k]   = a_p[k-1];
      nxt_b[k]   = b_p[k-1];
      nxt_res[k] = res_p[k-1];
      r = ripple_chunk(a_p[k-1][k*CHUNK +: CHUNK], b_p[k-1][k*CHUNK +: CHUNK], cy_p[k-1]);
      nxt_res[k][k*CHUNK +: CHUNK] = r[CHUNK-1:0];
      nxt_cy[k]  = r[CHUNK];
      nxt_ov[k]  = r[CHUNK+1];
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) vld_p[k] <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) vld_p[k] <= nxt_vld[k];
    end
  end

  // Data only moves with a valid token, so bubbles never disturb the visible result.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      res_p[STAGES-1] <= '0;
      cy_p[STAGES-1]  <= 1'b0;
      ov_p[STAGES-1]  <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        if (nxt_vld[k]) begin
          res_p[k] <= nxt_res[k];
          cy_p[k]  <= nxt_cy[k];
          ov_p[k]  <= nxt_ov[k];
          a_p[k]   <= nxt_a[k];
          b_p[k]   <= nxt_b[k];
        end
      end
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = vld_p[STAGES-1];
  assign bus.sum       = res_p[STAGES-1];
  assign bus.cout      = cy_p[STAGES-1];
  assign bus.overflow  = ov_p[STAGES-1];
endmodule
